// File: rtl/addsub_pkg.sv
// Shared constants and types for the serial adder/subtractor.
// Mode encodings and the two-state controller type.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/addsub_serial_if.sv
// Request/result bundle of the serial adder/subtractor.
// master = sequencer side, slave = arithmetic unit side.
interface addsub_serial_if #(
    parameter int WIDTH = 16
) ();

    logic             START;
    logic             MODE;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic             CO;
    logic             OV;
    logic             Z;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, MODE, A, B,
        input  S, CO, OV, Z, BUSY, DONE
    );

    modport slave (
        input  START, MODE, A, B,
        output S, CO, OV, Z, BUSY, DONE
    );

endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice.
// cm is the carry into the top bit, used for signed overflow.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             cm
);

    logic w_c;

    // ripple the carry through the slice, tapping the carry into the top bit
    always_comb begin
        s   = '0;
        w_c = ci;
        cm  = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            if (i == DIGIT - 1) begin
                cm = w_c;
            end
            w_c = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/sub, DIGIT bits per cycle from the LSB, WIDTH/DIGIT cycles.
// Optional ADDSUB_SAT_EN: signed saturation of S on overflow.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           CLK,
    input  logic           RST,
    addsub_serial_if.slave bus
);

    import addsub_pkg::*;

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_co;
    logic             r_ov;
    logic             r_z;
    logic             r_busy;
    logic             r_done;

    logic [DIGIT-1:0] w_sum;
    logic             w_co;
    logic             w_cm;
    logic             w_ov;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_s_fin;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a  (r_a[DIGIT-1:0]),
        .b  (r_b[DIGIT-1:0]),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co),
        .cm (w_cm)
    );

    // shift the new sum digit in at the top; after N cycles acc holds the result
    always_comb begin
        w_acc_nxt = r_acc >> DIGIT;
        w_acc_nxt[WIDTH-1 -: DIGIT] = w_sum;
        w_ov = w_cm ^ w_co;
`ifdef ADDSUB_SAT_EN
        if (w_ov) begin
            w_s_fin = w_acc_nxt[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            w_s_fin = w_acc_nxt;
        end
`else
        w_s_fin = w_acc_nxt;
`endif
    end

    // controller, operand shifters and registered results
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
            r_z     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B ^ {WIDTH{bus.MODE}};
                        r_carry <= bus.MODE;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_s     <= w_s_fin;
                        r_co    <= w_co;
                        r_ov    <= w_ov;
                        r_z     <= (w_s_fin == '0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.S    = r_s;
    assign bus.CO   = r_co;
    assign bus.OV   = r_ov;
    assign bus.Z    = r_z;
    assign bus.BUSY = r_busy;
    assign bus.DONE = r_done;

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle adder/subtractor: the next generation of the team's 8-bit ripple add/sub block. It computes A+B or A−B (two's complement, A + ~B + 1) over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle from the LSB. A START/BUSY/DONE handshake and registered result flags (carry, signed overflow, zero) make it usable as a shared arithmetic resource in sequencer-driven datapaths where one full-width ripple chain is too long for the clock.

## Interface
- WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request; sampled on CLK when BUSY=0.
- MODE  in  1  0 = add, 1 = subtract; sampled with START.
- A  in  WIDTH  operand A; sampled with START.
- B  in  WIDTH  operand B; sampled with START.
- S  out  WIDTH  result; registered, updated only on completion.
- CO  out  1  carry out of MSB (subtract: 1 = no borrow, A ≥ B unsigned).
- OV  out  1  signed overflow.
- Z  out  1  S == 0.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse: S/CO/OV/Z valid from this cycle.

## Operation
- N = WIDTH/DIGIT. States: IDLE, RUN.
- IDLE: START=1 → latch A, MODE, B^{WIDTH{MODE}} into operand registers; carry register ← MODE; digit counter ← 0; go RUN, BUSY=1.
- RUN: each cycle add operand digit [k*DIGIT +: DIGIT] with carry register; write sum digit into internal accumulator; carry register ← digit carry; counter +1.
- On last digit (counter = N−1): S ← accumulator incl. final digit; CO ← final carry; OV ← carry into MSB XOR carry out of MSB; Z ← (final S == 0); DONE=1 for that one cycle; BUSY ← 0; go IDLE.
- START while BUSY=1: ignored; operands and MODE not re-sampled.
- START in the cycle DONE is high: accepted (BUSY=0 then); new operation starts, S/flags hold old result until next completion.
- S, CO, OV, Z hold their values between completions.
- RST asserted at any time (incl. mid-RUN): immediate abort, state IDLE, all outputs and internal registers 0.

## Timing
- Reset values: S=0, CO=0, OV=0, Z=0, BUSY=0, DONE=0.
- START sampled high at edge 0 → BUSY high after edge 0; DONE high and results valid after edge N; BUSY low after edge N.
- Latency N cycles; throughput one operation per N cycles (back-to-back via START during DONE).
- N=1 (DIGIT=WIDTH): DONE one cycle after START.
- Critical path: one DIGIT-bit ripple plus carry register.

## Configuration
- ADDSUB_SAT_EN defined: signed saturation on completion; if OV=1, S ← 0x7F..F when result sign bit is 1 (positive overflow) or 0x80..0 when 0 (negative overflow). OV still reports the overflow; CO unaffected; Z computed on saturated S.
- ADDSUB_SAT_EN undefined: S is the wrapped modulo-2^WIDTH result; no saturation logic.

## Structure
- Package addsub_pkg: MODE_ADD=1'b0, MODE_SUB=1'b1 constants; state type (IDLE, RUN).
- Sub-module addsub_digit: combinational DIGIT-bit ripple slice; inputs a, b, ci; outputs s, co, and cm (carry into top bit, for OV). Top instantiates one.

## Test plan
All with WIDTH=16, DIGIT=4 (N=4) unless stated.
- ADD 0x1234+0x0FFF → S=0x2233, CO=0, OV=0, Z=0; DONE exactly 4 cycles after START, single-cycle pulse.
- SUB 0x0055−0x0015 → S=0x0040, CO=1, OV=0; SUB 0x0015−0x0055 → S=0xFFC0, CO=0, OV=0.
- ADD 0xFFFF+0x0001 → S=0x0000, CO=1, OV=0, Z=1.
- ADD 0x7FFF+0x0001 → OV=1, CO=0, S=0x8000 (S=0x7FFF with ADDSUB_SAT_EN); SUB 0x8000−0x0001 → OV=1, S=0x7FFF (S=0x8000 with ADDSUB_SAT_EN).
- START pulsed mid-RUN with different A/B → ignored, first result unaffected; START in DONE cycle → second result after 4 further cycles, S holds first result meanwhile.
- RST asserted in 2nd RUN cycle → BUSY=0, DONE=0, S=0, flags 0 immediately; no DONE afterwards; repeat with DIGIT=1 (N=16) and DIGIT=16 (N=1) for ADD 0x1234+0x0FFF → S=0x2233.
